// File: rtl/reg_bank_wr_arbiter.sv
// Register bank shared by N_REQ writers: arbitrate, capture, commit one write per transaction; combinational read port.
// Build option RR_ARB_EN: round-robin arbitration; undefined gives fixed priority (requester 0 highest).
module reg_bank_wr_arbiter #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 8,
   parameter  int N_REQ = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*AW-1:0]    req_addr,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [AW-1:0]          rd_addr,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   busy,
   output logic                   wr_done,
   output logic [IW-1:0]          wr_id
);

   typedef enum logic {IDLE = 1'b0, COMMIT = 1'b1} state_t;

   state_t            state_reg;
   logic [AW-1:0]     cap_addr_reg;
   logic [WIDTH-1:0]  cap_data_reg;
   logic [IW-1:0]     cap_id_reg;
   logic              wr_done_reg;
   logic [IW-1:0]     wr_id_reg;
   logic [WIDTH-1:0]  bank_reg [DEPTH];
   logic [DEPTH-1:0]  bank_we;

   logic              grant_found;
   logic [IW-1:0]     grant_idx;

`ifdef RR_ARB_EN
   logic [IW-1:0]     rr_ptr_reg;
   logic [IW-1:0]     rr_ptr_next;
   logic [IW:0]       scan_idx;

   // Scan rr_ptr, rr_ptr+1, ... modulo N_REQ (N_REQ need not be a power of 2)
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int j = 0; j < N_REQ; j++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (IW+1)'(j);
         if (scan_idx >= (IW+1)'(N_REQ))
            scan_idx = scan_idx - (IW+1)'(N_REQ);
         if (!grant_found && req_valid[scan_idx[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[IW-1:0];
         end
      end
   end

   assign rr_ptr_next = (grant_idx == IW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
`else
   // Descending scan: the lowest valid index is assigned last and wins
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int j = N_REQ-1; j >= 0; j--) begin
         if (req_valid[j]) begin
            grant_found = 1'b1;
            grant_idx   = IW'(j);
         end
      end
   end
`endif

   // Ready is held low while reset is asserted even though the winner logic is combinational
   assign req_ready = (rst_n && (state_reg == IDLE) && grant_found)
                      ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cap_addr_reg <= '0;
         cap_data_reg <= '0;
         cap_id_reg   <= '0;
         wr_done_reg  <= 1'b0;
         wr_id_reg    <= '0;
`ifdef RR_ARB_EN
         rr_ptr_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               wr_done_reg <= 1'b0;
               if (grant_found) begin
                  cap_addr_reg <= req_addr[grant_idx*AW +: AW];
                  cap_data_reg <= req_data[grant_idx*WIDTH +: WIDTH];
                  cap_id_reg   <= grant_idx;
                  state_reg    <= COMMIT;
`ifdef RR_ARB_EN
                  rr_ptr_reg   <= rr_ptr_next;
`endif
               end
            end
            COMMIT: begin
               wr_done_reg <= 1'b1;
               wr_id_reg   <= cap_id_reg;
               state_reg   <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank_we
         assign bank_we[gi] = (state_reg == COMMIT) && (cap_addr_reg == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++)
            bank_reg[k] <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            if (bank_we[k])
               bank_reg[k] <= cap_data_reg;
      end
   end

   assign rd_data = bank_reg[rd_addr];
   assign busy    = (state_reg == COMMIT);
   assign wr_done = wr_done_reg;
   assign wr_id   = wr_id_reg;

endmodule
